camo_key_loader: RTL and testbench

CAMO_KEY_LOADER -- requirements
Module: camo_key_loader

---
 rtl/camo_key_loader.sv | 108 ++++++++++
 tb/tb_camo_key_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/camo_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : camo_key_loader
// Purpose  : Serial MSB-first loader for the camouflaged-gate select key.
//            Bits shift into a shadow register; a commit in FULL copies the
//            shadow to the D bus that drives the camouflaged netlist.
// Revision : 1.0 - initial release
// ============================================================================
module camo_key_loader #(
  parameter int KEY_BITS = 30,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                key_bit_in,
  input  logic                key_bit_valid,
  output logic                key_bit_ready,
  input  logic                commit,
  input  logic                abort,
  output logic [KEY_BITS-1:0] D,
  output logic                key_valid,
  output logic [CNT_W-1:0]    bit_count,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] shadow_q, shadow_d;
  logic [KEY_BITS-1:0] d_q, d_d;
  logic                key_valid_q, key_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                w_accept;

  // A bit is taken only while shifting and the source presents one.
  assign key_bit_ready = (state_q == ST_SHIFT);
  assign w_accept      = key_bit_valid & key_bit_ready;

  // State register and key storage; reset puts every gate in pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      d_q         <= '0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      d_q         <= d_d;
      key_valid_q <= key_valid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; abort beats restart beats commit beats bit acceptance.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    d_d         = d_q;
    key_valid_d = key_valid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    if (abort) begin
      // Drop the partial load; the committed key and error flag survive.
      state_d  = ST_IDLE;
      shadow_d = '0;
      cnt_d    = '0;
    end else if (load_start) begin
      state_d  = ST_SHIFT;
      shadow_d = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else if (commit) begin
      if (state_q == ST_FULL) begin
        d_d         = shadow_q;
        key_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        // Committing a partial key is a protocol error; nothing moves.
        err_d = 1'b1;
      end
    end else if (w_accept) begin
      // Left shift makes the first bit end up in the MSB after KEY_BITS bits.
      shadow_d = {shadow_q[KEY_BITS-2:0], key_bit_in};
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
        state_d = ST_FULL;
      end
    end
  end

  assign D         = d_q;
  assign key_valid = key_valid_q;
  assign bit_count = cnt_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_camo_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_camo_key_loader
// Purpose  : Self-checking bench for camo_key_loader; committed keys are
//            queued on commit and compared when the D bus updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camo_key_loader;

  localparam int KEY_BITS = 30;
  localparam int CNT_W    = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load_start = 1'b0;
  logic                key_bit_in = 1'b0;
  logic                key_bit_valid = 1'b0;
  logic                key_bit_ready;
  logic                commit = 1'b0;
  logic                abort = 1'b0;
  logic [KEY_BITS-1:0] D;
  logic                key_valid;
  logic [CNT_W-1:0]    bit_count;
  logic                err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] exp_q[$];

  camo_key_loader #(.KEY_BITS(KEY_BITS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .key_bit_in   (key_bit_in),
    .key_bit_valid(key_bit_valid),
    .key_bit_ready(key_bit_ready),
    .commit       (commit),
    .abort        (abort),
    .D            (D),
    .key_valid    (key_valid),
    .bit_count    (bit_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  // Offer bits first..first+n-1 of pat (bit index 0 = MSB of the key).
  task automatic feed(input logic [63:0] pat, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      key_bit_in    = pat[KEY_BITS-1-i];
      key_bit_valid = 1'b1;
      cycle();
    end
    key_bit_valid = 1'b0;
    key_bit_in    = 1'b0;
  endtask

  // Commit a full key: expectation queued now, checked once D updates.
  task automatic commit_full(input logic [63:0] exp_key);
    logic [63:0] e;
    exp_q.push_back(exp_key);
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("D_after_commit", 64'(D), e);
      chk("key_valid_after_commit", 64'(key_valid), 64'd1);
      chk("ready_idle_after_commit", 64'(key_bit_ready), 64'd0);
    end
  endtask

  initial begin
    int acc;
    // Reset values while rst_n is held low.
    #3;
    chk("rst_D", 64'(D), 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_bit_count", 64'(bit_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(key_bit_ready), 64'd0);
    #9 rst_n = 1'b1;
    cycle();

    // Valid bits in IDLE are ignored.
    key_bit_valid = 1'b1;
    key_bit_in    = 1'b1;
    cycle();
    cycle();
    key_bit_valid = 1'b0;
    chk("idle_ignore_count", 64'(bit_count), 64'd0);
    chk("idle_ignore_err", 64'(err), 64'd0);

    // Early commit after 12 bits flags err, load continues.
    start_load();
    chk("start_count", 64'(bit_count), 64'd0);
    chk("start_ready", 64'(key_bit_ready), 64'd1);
    feed(64'h1F0F_3C5A, 0, 12);
    chk("early_count12", 64'(bit_count), 64'd12);
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    chk("early_err", 64'(err), 64'd1);
    chk("early_D", 64'(D), 64'd0);
    chk("early_key_valid", 64'(key_valid), 64'd0);
    chk("early_count_hold", 64'(bit_count), 64'd12);
    chk("early_still_shift", 64'(key_bit_ready), 64'd1);
    feed(64'h1F0F_3C5A, 12, 18);
    chk("early_count30", 64'(bit_count), 64'd30);
    commit_full(64'h1F0F_3C5A);
    chk("early_err_sticky", 64'(err), 64'd1);

    // Full load of 0x2AAAAAAA.
    start_load();
    chk("full_err_cleared", 64'(err), 64'd0);
    feed(64'h2AAA_AAAA, 0, KEY_BITS);
    chk("full_count", 64'(bit_count), 64'd30);
    chk("full_ready_low", 64'(key_bit_ready), 64'd0);
    chk("full_D_held", 64'(D), 64'h1F0F_3C5A);
    commit_full(64'h2AAA_AAAA);
    chk("full_err", 64'(err), 64'd0);

    // Backpressure: 35 bits offered, exactly 30 accepted.
    start_load();
    acc = 0;
    for (int i = 0; i < 35; i++) begin
      logic [63:0] p;
      p = 64'h1234_5678;
      key_bit_in    = (i < KEY_BITS) ? p[KEY_BITS-1-i] : 1'b1;
      key_bit_valid = 1'b1;
      if (key_bit_ready) acc++;
      if (i == KEY_BITS) chk("bp_ready_after_30th", 64'(key_bit_ready), 64'd0);
      cycle();
    end
    key_bit_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd30);
    chk("bp_count_sat", 64'(bit_count), 64'd30);
    chk("bp_D_undisturbed", 64'(D), 64'h2AAA_AAAA);
    chk("bp_key_valid_held", 64'(key_valid), 64'd1);
    commit_full(64'h1234_5678);

    // Abort and commit together in FULL: abort wins.
    start_load();
    feed(64'h0BAD_F00D, 0, KEY_BITS);
    abort  = 1'b1;
    commit = 1'b1;
    cycle();
    abort  = 1'b0;
    commit = 1'b0;
    chk("abort_D_kept", 64'(D), 64'h1234_5678);
    chk("abort_key_valid", 64'(key_valid), 64'd1);
    chk("abort_count", 64'(bit_count), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_idle_ready", 64'(key_bit_ready), 64'd0);
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    chk("idle_commit_err", 64'(err), 64'd1);
    chk("idle_commit_D", 64'(D), 64'h1234_5678);

    // Restart after 20 bits; only the new key is committed.
    start_load();
    feed(64'h1555_5555, 0, 20);
    chk("restart_pre_count", 64'(bit_count), 64'd20);
    start_load();
    chk("restart_count", 64'(bit_count), 64'd0);
    chk("restart_err", 64'(err), 64'd0);
    feed(64'h3C3C_0F0F, 0, KEY_BITS);
    commit_full(64'h3C3C_0F0F);

    // Asynchronous reset mid-load after committing all ones.
    start_load();
    feed(64'h3FFF_FFFF, 0, KEY_BITS);
    commit_full(64'h3FFF_FFFF);
    start_load();
    feed(64'h2AAA_AAAA, 0, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_D", 64'(D), 64'd0);
    chk("arst_key_valid", 64'(key_valid), 64'd0);
    chk("arst_count", 64'(bit_count), 64'd0);
    chk("arst_ready", 64'(key_bit_ready), 64'd0);
    #1 rst_n = 1'b1;
    cycle();
    chk("arst_post_count", 64'(bit_count), 64'd0);
    chk("arst_post_ready", 64'(key_bit_ready), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
